// File: rtl/rv32m_issue.sv
// rv32m_issue: initiator side of the M-extension start/finish handshake.
// Takes one MUL/DIV request, resolves divide corner cases locally or
// launches the multi-cycle unit, then returns the result with its tag.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/ready, req_a/b/m/rd execute-stage request
//   resp_valid/ready, resp_r/rd   result back to the pipeline
//   resp_err                      result produced by timeout
//   mdu_start/a/b/m               launch of the multi-cycle unit
//   mdu_finish, mdu_r             completion from the unit
//   busy                          operation in flight
module rv32m_issue #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_a,
  input  logic [31:0]   req_b,
  input  logic [2:0]    req_m,
  input  logic [TW-1:0] req_rd,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_r,
  output logic [TW-1:0] resp_rd,
  output logic          resp_err,
  output logic          mdu_start,
  output logic [31:0]   mdu_a,
  output logic [31:0]   mdu_b,
  output logic [2:0]    mdu_m,
  input  logic          mdu_finish,
  input  logic [31:0]   mdu_r,
  output logic          busy
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [2:0]    m_q;
  logic [TW-1:0] rd_q;
  logic [31:0]   r_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          fast_hit;
  logic [31:0]   fast_r;

  // Divide corner cases answered without the unit.
  // Overflow only applies to the signed ops (m[0]=0).
  always_comb begin
    fast_hit = 1'b0;
    fast_r   = 32'h0;
    if (req_m[2]) begin
      if (req_b == 32'h0) begin
        fast_hit = 1'b1;
        fast_r   = req_m[1] ? req_a : 32'hFFFF_FFFF;
      end else if (!req_m[0] &&
                   req_a == 32'h8000_0000 &&
                   req_b == 32'hFFFF_FFFF) begin
        fast_hit = 1'b1;
        fast_r   = req_m[1] ? 32'h0 : 32'h8000_0000;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      rd_q    <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            m_q   <= req_m;
            rd_q  <= req_rd;
            err_q <= 1'b0;
            cnt_q <= '0;
            if (fast_hit) begin
              r_q     <= fast_r;
              state_q <= S_RESP;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // finish takes priority over a same-cycle timeout
          if (mdu_finish) begin
            r_q     <= mdu_r;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (cnt_q == TMAX) begin
            r_q     <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mdu_start  = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_r     = r_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign mdu_a      = a_q;
  assign mdu_b      = b_q;
  assign mdu_m      = m_q;

endmodule

// File: tb/tb_rv32m_issue.sv
// tb_rv32m_issue: directed bench for rv32m_issue.
// Includes a small multi-cycle unit model with programmable latency.
module tb_rv32m_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_m = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_r;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        mdu_start;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic [2:0]  mdu_m;
  logic        mdu_finish = 1'b0;
  logic [31:0] mdu_r = '0;
  logic        busy;

  int passed = 0;
  int total  = 0;

  // unit model: finish on the mdl_lat-th cycle after the start cycle
  // (mdl_lat = 0 means never)
  int          mdl_lat = 0;
  logic [31:0] mdl_r = '0;
  int          mdl_cnt = 0;

  always #5 clk = ~clk;

  rv32m_issue #(.TIMEOUT_CYCLES(64), .TW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_m(req_m), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_r(resp_r), .resp_rd(resp_rd),
    .resp_err(resp_err),
    .mdu_start(mdu_start),
    .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_m(mdu_m),
    .mdu_finish(mdu_finish), .mdu_r(mdu_r),
    .busy(busy)
  );

  always @(posedge clk) begin
    mdu_r <= mdl_r;
    if (mdu_start) begin
      mdl_cnt    <= 1;
      mdu_finish <= (mdl_lat == 1);
    end else if (mdl_cnt != 0) begin
      mdu_finish <= (mdl_cnt + 1 == mdl_lat);
      mdl_cnt    <= (mdl_cnt + 1 == mdl_lat) ? 0 : mdl_cnt + 1;
    end else begin
      mdu_finish <= 1'b0;
    end
  end

  // Presents one request (call at a negedge), stops at the first
  // negedge with resp_valid, leaving resp_ready low.
  // lat = negedges from acceptance to resp_valid, -1 on expiry.
  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  m,
    input  logic [4:0]  rd,
    output logic [31:0] r,
    output logic        err,
    output logic [4:0]  ord,
    output int          lat,
    output int          starts,
    output logic        stable
  );
    int n;
    req_a = a; req_b = b; req_m = m; req_rd = rd;
    req_valid = 1'b1;
    r = '0; err = 1'b0; ord = '0;
    lat = -1; starts = 0; stable = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    n = 1;
    while (n <= 200) begin
      if (mdu_start) starts++;
      if (resp_valid) begin
        lat = n; r = resp_r;
        err = resp_err; ord = resp_rd;
        break;
      end
      if (mdu_a !== a || mdu_b !== b || mdu_m !== m)
        stable = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic xfer();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        err;
  logic [4:0]  ord;
  int          lat;
  int          st;
  logic        stab;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, mdu_start, busy} !== 5'b10000)
      $display("FAIL rst_ctrl got %b want 10000",
        {req_ready, resp_valid, resp_err, mdu_start, busy});
    else passed++;
    total++;
    if ({resp_r, resp_rd, mdu_a, mdu_b, mdu_m} !== '0)
      $display("FAIL rst_data got r=%h rd=%h a=%h b=%h m=%h want 0",
        resp_r, resp_rd, mdu_a, mdu_b, mdu_m);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, busy} !== 2'b10)
      $display("FAIL rst_idle got %b want 10", {req_ready, busy});
    else passed++;
  endtask

  task automatic test_slow_signed();
    mdl_lat = 33; mdl_r = 32'hFFFF_FFFD;
    run_op(32'hFFFF_FFE7, 32'd8, 3'b100, 5'd7,
           r, err, ord, lat, st, stab);
    total++;
    if ({r, err, ord} !== {32'hFFFF_FFFD, 1'b0, 5'd7})
      $display("FAIL div_s got r=%h e=%b rd=%0d want fffffffd 0 7",
        r, err, ord);
    else passed++;
    total++;
    if (st !== 1 || stab !== 1'b1 || lat !== 35)
      $display("FAIL div_s_hs got st=%0d stab=%b lat=%0d want 1 1 35",
        st, stab, lat);
    else passed++;
    xfer();
    mdl_r = 32'hFFFF_FFFF;
    run_op(32'hFFFF_FFE7, 32'd8, 3'b110, 5'd12,
           r, err, ord, lat, st, stab);
    total++;
    if ({r, err, ord} !== {32'hFFFF_FFFF, 1'b0, 5'd12})
      $display("FAIL rem_s got r=%h e=%b rd=%0d want ffffffff 0 12",
        r, err, ord);
    else passed++;
    total++;
    if (st !== 1 || stab !== 1'b1 || lat !== 35)
      $display("FAIL rem_s_hs got st=%0d stab=%b lat=%0d want 1 1 35",
        st, stab, lat);
    else passed++;
    xfer();
  endtask

  task automatic test_back_to_back();
    logic ok;
    mdl_lat = 10; mdl_r = 32'd6;
    run_op(32'd80, 32'd13, 3'b101, 5'd3,
           r, err, ord, lat, st, stab);
    total++;
    if ({r, err, ord} !== {32'd6, 1'b0, 5'd3} || lat !== 12)
      $display("FAIL divu got r=%0d e=%b rd=%0d lat=%0d want 6 0 3 12",
        r, err, ord, lat);
    else passed++;
    // next request waits while the response is unclaimed
    mdl_r = 32'd2;
    req_a = 32'd80; req_b = 32'd13;
    req_m = 3'b111; req_rd = 5'd4;
    req_valid = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 ||
          resp_rd !== 5'd3 || mdu_m !== 3'b101 || resp_r !== 32'd6)
        ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1)
      $display("FAIL b2b_hold got ok=%b want 1", ok);
    else passed++;
    resp_ready = 1'b1;
    run_op(32'd80, 32'd13, 3'b111, 5'd4,
           r, err, ord, lat, st, stab);
    total++;
    if ({r, err, ord} !== {32'd2, 1'b0, 5'd4} || st !== 1)
      $display("FAIL remu got r=%0d e=%b rd=%0d st=%0d want 2 0 4 1",
        r, err, ord, st);
    else passed++;
    xfer();
  endtask

  task automatic test_div_zero();
    run_op(32'h1234, 32'd0, 3'b101, 5'd1,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'hFFFF_FFFF || lat !== 1 || st !== 0)
      $display("FAIL divu0 got r=%h lat=%0d st=%0d want ffffffff 1 0",
        r, lat, st);
    else passed++;
    xfer();
    run_op(32'h1234, 32'd0, 3'b111, 5'd2,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'h1234 || lat !== 1 || st !== 0 || ord !== 5'd2)
      $display("FAIL remu0 got r=%h lat=%0d st=%0d rd=%0d want 1234 1 0 2",
        r, lat, st, ord);
    else passed++;
    xfer();
    total++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL fast_xfer got %b want 01", {resp_valid, req_ready});
    else passed++;
  endtask

  task automatic test_overflow();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 5'd5,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'h8000_0000 || lat !== 1 || st !== 0)
      $display("FAIL div_ovf got r=%h lat=%0d st=%0d want 80000000 1 0",
        r, lat, st);
    else passed++;
    xfer();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 5'd6,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'h0 || lat !== 1 || st !== 0)
      $display("FAIL rem_ovf got r=%h lat=%0d st=%0d want 0 1 0",
        r, lat, st);
    else passed++;
    xfer();
    // unsigned op with the same operands goes to the unit
    mdl_lat = 2; mdl_r = 32'd0;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b101, 5'd8,
           r, err, ord, lat, st, stab);
    total++;
    if (st !== 1 || lat !== 4)
      $display("FAIL divu_ovf got st=%0d lat=%0d want 1 4", st, lat);
    else passed++;
    xfer();
  endtask

  task automatic test_mul_zero();
    mdl_lat = 3; mdl_r = 32'd0;
    run_op(32'd0, 32'd0, 3'b000, 5'd9,
           r, err, ord, lat, st, stab);
    total++;
    if (st !== 1 || lat !== 5 || r !== 32'd0 || ord !== 5'd9)
      $display("FAIL mul0 got st=%0d lat=%0d r=%h rd=%0d want 1 5 0 9",
        st, lat, r, ord);
    else passed++;
    xfer();
  endtask

  task automatic test_backpressure();
    logic ok;
    run_op(32'd7, 32'd0, 3'b100, 5'd10,
           r, err, ord, lat, st, stab);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_r !== 32'hFFFF_FFFF ||
          resp_rd !== 5'd10 || resp_err !== 1'b0)
        ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1)
      $display("FAIL bp_hold got ok=%b want 1", ok);
    else passed++;
    xfer();
  endtask

  task automatic test_timeout();
    mdl_lat = 0; mdl_r = 32'hDEAD_BEEF;
    run_op(32'd100, 32'd9, 3'b101, 5'd11,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'd0 || err !== 1'b1 || lat !== 66)
      $display("FAIL tmo got r=%h e=%b lat=%0d want 0 1 66",
        r, err, lat);
    else passed++;
    xfer();
    mdl_lat = 64; mdl_r = 32'hCAFE_0001;
    run_op(32'd100, 32'd9, 3'b101, 5'd13,
           r, err, ord, lat, st, stab);
    total++;
    if (r !== 32'hCAFE_0001 || err !== 1'b0 || lat !== 66)
      $display("FAIL tmo_edge got r=%h e=%b lat=%0d want cafe0001 0 66",
        r, err, lat);
    else passed++;
    xfer();
  endtask

  task automatic test_reset_mid();
    logic seen;
    mdl_lat = 40; mdl_r = 32'h5555_5555;
    req_a = 32'd50; req_b = 32'd7;
    req_m = 3'b100; req_rd = 5'd14;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1)
      $display("FAIL mid_busy got %b want 1", busy);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, busy, mdu_start} !== 4'b1000 ||
        {mdu_a, mdu_b, mdu_m, resp_r, resp_rd} !== '0)
      $display("FAIL mid_rst got ctl=%b a=%h r=%h want 1000 0 0",
        {req_ready, resp_valid, busy, mdu_start}, mdu_a, resp_r);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL mid_late got seen=%b want 0", seen);
    else passed++;
    mdl_lat = 4; mdl_r = 32'd21;
    run_op(32'd147, 32'd7, 3'b101, 5'd15,
           r, err, ord, lat, st, stab);
    total++;
    if ({r, err, ord} !== {32'd21, 1'b0, 5'd15} || lat !== 6)
      $display("FAIL mid_next got r=%0d e=%b rd=%0d lat=%0d want 21 0 15 6",
        r, err, ord, lat);
    else passed++;
    xfer();
  endtask

  initial begin
    test_reset();
    test_slow_signed();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_mul_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
